// File: rtl/match_result_collector.sv
// Collects matcher result strobes per scene descriptor and queues {match, scene, db index} words in a FWFT FIFO.
// Optional STORE_NONMATCH_EN: when defined, non-matching scenes are queued too.
module match_result_collector #(
   parameter int ADDR_W = 8
) (
   input  logic              iClk,
   input  logic              iRst_n,
   input  logic              iClear,
   input  logic              iSceneStart,
   input  logic [11:0]       iNumDbDesc,
   input  logic              iMatch,
   input  logic [11:0]       iMatchIndex,
   input  logic              iMatch_Valid,
   input  logic              iRdReq,
   output logic [31:0]       oRdData,
   output logic              oEmpty,
   output logic [ADDR_W:0]   oCount,
   output logic              oOverflow,
   output logic              oBusy,
   output logic [11:0]       oScenesDone
);

   // state   | meaning
   // IDLE    | no scene in progress, strobes ignored
   // COLLECT | counting strobes of the current scene descriptor
   localparam logic [0:0] IDLE    = 1'b0;
   localparam logic [0:0] COLLECT = 1'b1;

   localparam int DEPTH = 1 << ADDR_W;
   localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W+1)'(DEPTH);

   logic [0:0]        state;
   logic [11:0]       sceneCnt;
   logic [11:0]       curScene;
   logic [11:0]       numDb;
   logic [11:0]       dbCnt;
   logic [11:0]       scenesDone;
   logic [31:0]       mem [DEPTH];
   logic [ADDR_W-1:0] wrPtr;
   logic [ADDR_W-1:0] rdPtr;
   logic [ADDR_W:0]   count;
   logic              overflow;

   logic        finalStrobe;
   logic        zeroDone;
   logic        keepEntry;
   logic        pushReq;
   logic        popOk;
   logic        pushOk;
   logic        dropped;
   logic        empty;
   logic        full;
   logic [31:0] entry;

   assign finalStrobe = (state == COLLECT) && iMatch_Valid && (numDb != 12'd0)
                        && (dbCnt == numDb - 12'd1);
   // A zero-length scene completes one cycle after its start without an entry.
   assign zeroDone    = (state == COLLECT) && (numDb == 12'd0);

`ifdef STORE_NONMATCH_EN
   assign keepEntry = 1'b1;
`else
   assign keepEntry = iMatch;
`endif

   assign empty   = (count == '0);
   assign full    = (count == FULL_CNT);
   assign pushReq = finalStrobe && keepEntry;
   assign popOk   = iRdReq && !empty;
   assign pushOk  = pushReq && (!full || popOk);
   assign dropped = pushReq && full && !popOk;
   assign entry   = {iMatch, 3'b000, curScene, 4'b0000, iMatchIndex};

   always_ff @(posedge iClk or negedge iRst_n) begin
      if (!iRst_n) begin
         state      <= IDLE;
         sceneCnt   <= '0;
         curScene   <= '0;
         numDb      <= '0;
         dbCnt      <= '0;
         scenesDone <= '0;
         wrPtr      <= '0;
         rdPtr      <= '0;
         count      <= '0;
         overflow   <= 1'b0;
      end else if (iClear) begin
         state      <= IDLE;
         sceneCnt   <= '0;
         curScene   <= '0;
         numDb      <= '0;
         dbCnt      <= '0;
         scenesDone <= '0;
         wrPtr      <= '0;
         rdPtr      <= '0;
         count      <= '0;
         overflow   <= 1'b0;
      end else begin
         if (state == COLLECT && iMatch_Valid)
            dbCnt <= dbCnt + 12'd1;
         if (finalStrobe || zeroDone) begin
            scenesDone <= scenesDone + 12'd1;
            state      <= IDLE;
         end
         // A new start wins over completion for scene bookkeeping; the old scene is already closed above.
         if (iSceneStart) begin
            curScene <= sceneCnt;
            sceneCnt <= sceneCnt + 12'd1;
            numDb    <= iNumDbDesc;
            dbCnt    <= '0;
            state    <= COLLECT;
         end
         if (pushOk)
            wrPtr <= wrPtr + 1'b1;
         if (popOk)
            rdPtr <= rdPtr + 1'b1;
         case ({pushOk, popOk})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
         if (dropped)
            overflow <= 1'b1;
      end
   end

   always_ff @(posedge iClk) begin
      if (pushOk && !iClear && iRst_n)
         mem[wrPtr] <= entry;
   end

   assign oRdData     = empty ? 32'd0 : mem[rdPtr];
   assign oEmpty      = empty;
   assign oCount      = count;
   assign oOverflow   = overflow;
   assign oBusy       = (state == COLLECT);
   assign oScenesDone = scenesDone;

endmodule

// File: tb/tb_match_result_collector.sv
// Directed self-checking bench for match_result_collector built with a 4-entry FIFO.
module tb_match_result_collector;

   localparam int ADDR_W = 2;

   logic              iClk;
   logic              iRst_n;
   logic              iClear;
   logic              iSceneStart;
   logic [11:0]       iNumDbDesc;
   logic              iMatch;
   logic [11:0]       iMatchIndex;
   logic              iMatch_Valid;
   logic              iRdReq;
   logic [31:0]       oRdData;
   logic              oEmpty;
   logic [ADDR_W:0]   oCount;
   logic              oOverflow;
   logic              oBusy;
   logic [11:0]       oScenesDone;

   int nCmp  = 0;
   int nFail = 0;

   match_result_collector #(.ADDR_W(ADDR_W)) dut (
      .iClk         (iClk),
      .iRst_n       (iRst_n),
      .iClear       (iClear),
      .iSceneStart  (iSceneStart),
      .iNumDbDesc   (iNumDbDesc),
      .iMatch       (iMatch),
      .iMatchIndex  (iMatchIndex),
      .iMatch_Valid (iMatch_Valid),
      .iRdReq       (iRdReq),
      .oRdData      (oRdData),
      .oEmpty       (oEmpty),
      .oCount       (oCount),
      .oOverflow    (oOverflow),
      .oBusy        (oBusy),
      .oScenesDone  (oScenesDone)
   );

   initial iClk = 1'b0;
   always #5 iClk = ~iClk;

   task automatic tick();
      @(posedge iClk);
      #1;
   endtask

   task automatic idleInputs();
      iClear       = 1'b0;
      iSceneStart  = 1'b0;
      iNumDbDesc   = 12'd0;
      iMatch       = 1'b0;
      iMatchIndex  = 12'd0;
      iMatch_Valid = 1'b0;
      iRdReq       = 1'b0;
   endtask

   task automatic doReset();
      idleInputs();
      iRst_n = 1'b0;
      tick();
      tick();
      iRst_n = 1'b1;
      tick();
   endtask

   task automatic startScene(input logic [11:0] n);
      iSceneStart = 1'b1;
      iNumDbDesc  = n;
      tick();
      iSceneStart = 1'b0;
   endtask

   task automatic strobe(input logic m, input logic [11:0] idx);
      iMatch_Valid = 1'b1;
      iMatch       = m;
      iMatchIndex  = idx;
      tick();
      iMatch_Valid = 1'b0;
      iMatch       = 1'b0;
   endtask

   task automatic test_reset();
      doReset();
      nCmp++; if (oRdData !== 32'd0) begin nFail++; $display("FAIL reset_rddata: got %h need 0", oRdData); end
      nCmp++; if (oEmpty !== 1'b1) begin nFail++; $display("FAIL reset_empty: got %b need 1", oEmpty); end
      nCmp++; if (oCount !== 3'd0) begin nFail++; $display("FAIL reset_count: got %0d need 0", oCount); end
      nCmp++; if (oOverflow !== 1'b0) begin nFail++; $display("FAIL reset_overflow: got %b need 0", oOverflow); end
      nCmp++; if (oBusy !== 1'b0) begin nFail++; $display("FAIL reset_busy: got %b need 0", oBusy); end
      nCmp++; if (oScenesDone !== 12'd0) begin nFail++; $display("FAIL reset_scenes: got %0d need 0", oScenesDone); end
   endtask

   task automatic test_basic_match();
      doReset();
      startScene(12'd3);
      nCmp++; if (oBusy !== 1'b1) begin nFail++; $display("FAIL basic_busy_rise: got %b need 1", oBusy); end
      strobe(1'b0, 12'h001);
      strobe(1'b0, 12'h007);
      nCmp++; if (oEmpty !== 1'b1) begin nFail++; $display("FAIL basic_early_entry: empty %b need 1", oEmpty); end
      strobe(1'b1, 12'h02A);
      nCmp++; if (oRdData !== 32'h8000_002A) begin nFail++; $display("FAIL basic_rddata: got %h need 8000002a", oRdData); end
      nCmp++; if (oCount !== 3'd1) begin nFail++; $display("FAIL basic_count: got %0d need 1", oCount); end
      nCmp++; if (oScenesDone !== 12'd1) begin nFail++; $display("FAIL basic_scenes: got %0d need 1", oScenesDone); end
      nCmp++; if (oBusy !== 1'b0) begin nFail++; $display("FAIL basic_busy_fall: got %b need 0", oBusy); end
      // Strobes in IDLE must not start or complete anything.
      strobe(1'b1, 12'h033);
      nCmp++; if (oCount !== 3'd1) begin nFail++; $display("FAIL idle_strobe_count: got %0d need 1", oCount); end
   endtask

   task automatic test_nonmatch();
      doReset();
      startScene(12'd3);
      strobe(1'b1, 12'h001);
      strobe(1'b1, 12'h002);
      strobe(1'b0, 12'h02A);
      nCmp++; if (oScenesDone !== 12'd1) begin nFail++; $display("FAIL nonmatch_scenes: got %0d need 1", oScenesDone); end
`ifdef STORE_NONMATCH_EN
      nCmp++; if (oRdData !== 32'h0000_002A) begin nFail++; $display("FAIL nonmatch_rddata: got %h need 0000002a", oRdData); end
      nCmp++; if (oEmpty !== 1'b0) begin nFail++; $display("FAIL nonmatch_empty: got %b need 0", oEmpty); end
`else
      nCmp++; if (oEmpty !== 1'b1) begin nFail++; $display("FAIL nonmatch_empty: got %b need 1", oEmpty); end
      nCmp++; if (oRdData !== 32'd0) begin nFail++; $display("FAIL nonmatch_rddata: got %h need 0", oRdData); end
`endif
   endtask

   task automatic test_abort();
      doReset();
      startScene(12'd4);
      strobe(1'b1, 12'h001);
      strobe(1'b1, 12'h002);
      startScene(12'd2);
      strobe(1'b1, 12'h005);
      strobe(1'b1, 12'h005);
      nCmp++; if (oRdData !== 32'h8001_0005) begin nFail++; $display("FAIL abort_rddata: got %h need 80010005", oRdData); end
      nCmp++; if (oCount !== 3'd1) begin nFail++; $display("FAIL abort_count: got %0d need 1", oCount); end
      nCmp++; if (oScenesDone !== 12'd1) begin nFail++; $display("FAIL abort_scenes: got %0d need 1", oScenesDone); end
   endtask

   task automatic test_zero_db();
      doReset();
      startScene(12'd0);
      nCmp++; if (oBusy !== 1'b1) begin nFail++; $display("FAIL zero_busy_rise: got %b need 1", oBusy); end
      tick();
      nCmp++; if (oBusy !== 1'b0) begin nFail++; $display("FAIL zero_busy_fall: got %b need 0", oBusy); end
      nCmp++; if (oScenesDone !== 12'd1) begin nFail++; $display("FAIL zero_scenes: got %0d need 1", oScenesDone); end
      nCmp++; if (oEmpty !== 1'b1) begin nFail++; $display("FAIL zero_empty: got %b need 1", oEmpty); end
   endtask

   task automatic test_same_cycle();
      doReset();
      startScene(12'd2);
      strobe(1'b0, 12'h001);
      iSceneStart  = 1'b1;
      iNumDbDesc   = 12'd1;
      iMatch_Valid = 1'b1;
      iMatch       = 1'b1;
      iMatchIndex  = 12'h003;
      tick();
      idleInputs();
      nCmp++; if (oRdData !== 32'h8000_0003) begin nFail++; $display("FAIL same_old_entry: got %h need 80000003", oRdData); end
      nCmp++; if (oBusy !== 1'b1) begin nFail++; $display("FAIL same_busy: got %b need 1", oBusy); end
      strobe(1'b1, 12'h004);
      nCmp++; if (oScenesDone !== 12'd2) begin nFail++; $display("FAIL same_scenes: got %0d need 2", oScenesDone); end
      iRdReq = 1'b1;
      tick();
      iRdReq = 1'b0;
      nCmp++; if (oRdData !== 32'h8001_0004) begin nFail++; $display("FAIL same_new_entry: got %h need 80010004", oRdData); end
   endtask

   task automatic test_overflow();
      doReset();
      for (int i = 0; i < 4; i++) begin
         startScene(12'd1);
         strobe(1'b1, 12'(i));
      end
      nCmp++; if (oCount !== 3'd4) begin nFail++; $display("FAIL ovf_fill_count: got %0d need 4", oCount); end
      nCmp++; if (oOverflow !== 1'b0) begin nFail++; $display("FAIL ovf_fill_flag: got %b need 0", oOverflow); end
      startScene(12'd1);
      iRdReq = 1'b1;
      strobe(1'b1, 12'h004);
      iRdReq = 1'b0;
      nCmp++; if (oCount !== 3'd4) begin nFail++; $display("FAIL ovf_pushpop_count: got %0d need 4", oCount); end
      nCmp++; if (oOverflow !== 1'b0) begin nFail++; $display("FAIL ovf_pushpop_flag: got %b need 0", oOverflow); end
      nCmp++; if (oRdData !== 32'h8001_0001) begin nFail++; $display("FAIL ovf_pushpop_head: got %h need 80010001", oRdData); end
      startScene(12'd1);
      strobe(1'b1, 12'h005);
      nCmp++; if (oCount !== 3'd4) begin nFail++; $display("FAIL ovf_drop_count: got %0d need 4", oCount); end
      nCmp++; if (oOverflow !== 1'b1) begin nFail++; $display("FAIL ovf_drop_flag: got %b need 1", oOverflow); end
      nCmp++; if (oScenesDone !== 12'd6) begin nFail++; $display("FAIL ovf_scenes: got %0d need 6", oScenesDone); end
   endtask

   task automatic test_drain();
      logic [31:0] exp;
      doReset();
      for (int i = 0; i < 4; i++) begin
         startScene(12'd1);
         strobe(1'b1, 12'(i + 16));
      end
      iRdReq = 1'b1;
      for (int i = 0; i < 4; i++) begin
         exp = {1'b1, 3'b000, 12'(i), 4'b0000, 12'(i + 16)};
         nCmp++; if (oRdData !== exp) begin nFail++; $display("FAIL drain_entry%0d: got %h need %h", i, oRdData, exp); end
         tick();
      end
      iRdReq = 1'b0;
      nCmp++; if (oEmpty !== 1'b1) begin nFail++; $display("FAIL drain_empty: got %b need 1", oEmpty); end
      nCmp++; if (oRdData !== 32'd0) begin nFail++; $display("FAIL drain_rddata: got %h need 0", oRdData); end
      iRdReq = 1'b1;
      tick();
      iRdReq = 1'b0;
      nCmp++; if (oCount !== 3'd0) begin nFail++; $display("FAIL drain_extra_pop: got %0d need 0", oCount); end
   endtask

   task automatic test_clear();
      doReset();
      startScene(12'd1);
      strobe(1'b1, 12'h001);
      startScene(12'd3);
      strobe(1'b0, 12'h000);
      iClear       = 1'b1;
      iSceneStart  = 1'b1;
      iNumDbDesc   = 12'd5;
      iMatch_Valid = 1'b1;
      iRdReq       = 1'b1;
      tick();
      idleInputs();
      nCmp++; if (oRdData !== 32'd0) begin nFail++; $display("FAIL clear_rddata: got %h need 0", oRdData); end
      nCmp++; if (oEmpty !== 1'b1) begin nFail++; $display("FAIL clear_empty: got %b need 1", oEmpty); end
      nCmp++; if (oCount !== 3'd0) begin nFail++; $display("FAIL clear_count: got %0d need 0", oCount); end
      nCmp++; if (oBusy !== 1'b0) begin nFail++; $display("FAIL clear_busy: got %b need 0", oBusy); end
      nCmp++; if (oScenesDone !== 12'd0) begin nFail++; $display("FAIL clear_scenes: got %0d need 0", oScenesDone); end
      startScene(12'd1);
      strobe(1'b1, 12'h009);
      nCmp++; if (oRdData !== 32'h8000_0009) begin nFail++; $display("FAIL clear_next_tag: got %h need 80000009", oRdData); end
   endtask

   task automatic test_rst_mid_scene();
      doReset();
      startScene(12'd1);
      strobe(1'b1, 12'h001);
      startScene(12'd3);
      strobe(1'b0, 12'h000);
      #2;
      iRst_n = 1'b0;
      #1;
      nCmp++; if (oBusy !== 1'b0) begin nFail++; $display("FAIL rst_busy: got %b need 0", oBusy); end
      nCmp++; if (oCount !== 3'd0) begin nFail++; $display("FAIL rst_count: got %0d need 0", oCount); end
      nCmp++; if (oEmpty !== 1'b1) begin nFail++; $display("FAIL rst_empty: got %b need 1", oEmpty); end
      nCmp++; if (oRdData !== 32'd0) begin nFail++; $display("FAIL rst_rddata: got %h need 0", oRdData); end
      nCmp++; if (oScenesDone !== 12'd0) begin nFail++; $display("FAIL rst_scenes: got %0d need 0", oScenesDone); end
      tick();
      iRst_n = 1'b1;
      tick();
      startScene(12'd1);
      strobe(1'b1, 12'h007);
      nCmp++; if (oRdData !== 32'h8000_0007) begin nFail++; $display("FAIL rst_next_tag: got %h need 80000007", oRdData); end
   endtask

   initial begin
      iRst_n = 1'b0;
      idleInputs();
      test_reset();
      test_basic_match();
      test_nonmatch();
      test_abort();
      test_zero_db();
      test_same_cycle();
      test_overflow();
      test_drain();
      test_clear();
      test_rst_mid_scene();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nFail);
      $finish;
   end

endmodule
